// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display blocks: active-low glyphs,
// blank/off patterns and the update-handshake state encoding.
package display_pkg;

  localparam int unsigned SegW   = 7;
  localparam int unsigned AnodeW = 4;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SegW-1:0] SEG_0 = 7'h40;
  localparam logic [SegW-1:0] SEG_1 = 7'h79;
  localparam logic [SegW-1:0] SEG_2 = 7'h24;
  localparam logic [SegW-1:0] SEG_3 = 7'h30;
  localparam logic [SegW-1:0] SEG_4 = 7'h19;
  localparam logic [SegW-1:0] SEG_5 = 7'h12;
  localparam logic [SegW-1:0] SEG_6 = 7'h02;
  localparam logic [SegW-1:0] SEG_7 = 7'h78;
  localparam logic [SegW-1:0] SEG_8 = 7'h00;
  localparam logic [SegW-1:0] SEG_9 = 7'h10;
  localparam logic [SegW-1:0] SEG_A = 7'h08;
  localparam logic [SegW-1:0] SEG_B = 7'h03;
  localparam logic [SegW-1:0] SEG_C = 7'h46;
  localparam logic [SegW-1:0] SEG_D = 7'h21;
  localparam logic [SegW-1:0] SEG_E = 7'h06;
  localparam logic [SegW-1:0] SEG_F = 7'h0E;

  localparam logic [SegW-1:0]   SEG_BLANK  = 7'h7F;
  localparam logic [AnodeW-1:0] ANODES_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } hsState_e;

endpackage

// File: rtl/hex_to_segments.sv
// Combinational hex digit to active-low seven-segment glyph decoder.
module hex_to_segments
  import display_pkg::*;
(
  input  logic [3:0]      nibble,
  output logic [SegW-1:0] glyph_c
);

  always_comb begin
    glyph_c = SEG_BLANK;
    case (nibble)
      4'h0: glyph_c = SEG_0;
      4'h1: glyph_c = SEG_1;
      4'h2: glyph_c = SEG_2;
      4'h3: glyph_c = SEG_3;
      4'h4: glyph_c = SEG_4;
      4'h5: glyph_c = SEG_5;
      4'h6: glyph_c = SEG_6;
      4'h7: glyph_c = SEG_7;
      4'h8: glyph_c = SEG_8;
      4'h9: glyph_c = SEG_9;
      4'hA: glyph_c = SEG_A;
      4'hB: glyph_c = SEG_B;
      4'hC: glyph_c = SEG_C;
      4'hD: glyph_c = SEG_D;
      4'hE: glyph_c = SEG_E;
      4'hF: glyph_c = SEG_F;
      default: glyph_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed hex display driver with a req/ack update port,
// per-dwell anti-ghosting guard and optional leading-zero blanking.
module seven_segment_scanner
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIVIDER_BITS   = 16,
  parameter int unsigned GUARD_CYCLES        = 4,
  parameter bit          BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              updateReq,
  input  logic [15:0]       value,
  input  logic [3:0]        dpMask,
  output logic              updateAck,
  output logic [AnodeW-1:0] anodes,
  output logic [SegW-1:0]   segments,
  output logic              dp
);

  localparam int unsigned ValueW = 16;
  localparam int unsigned MaskW  = 4;
  localparam int unsigned DigitW = 2;

  hsState_e                     state, stateNext;
  logic                         ackNext;
  logic [ValueW-1:0]            dispValue, dispValueNext;
  logic [MaskW-1:0]             dispMask, dispMaskNext;
  logic [SCAN_DIVIDER_BITS-1:0] prescaler, prescalerNext;
  logic [DigitW-1:0]            digitIndex, digitIndexNext;
  logic [3:0]                   nibbleSel;
  logic                         leadZero;
  logic [SegW-1:0]              glyph;
  logic [AnodeW-1:0]            anodesNext;
  logic [SegW-1:0]              segmentsNext;
  logic                         dpNext;

  // Handshake: latch on accept, ack once, then wait for the request to drop
  always_comb begin
    stateNext     = state;
    ackNext       = 1'b0;
    dispValueNext = dispValue;
    dispMaskNext  = dispMask;
    case (state)
      IDLE: begin
        if (updateReq) begin
          stateNext     = ACK;
          dispValueNext = value;
          dispMaskNext  = dpMask;
        end
      end
      ACK: begin
        stateNext = WAIT_LOW;
        ackNext   = 1'b1;
      end
      WAIT_LOW: begin
        if (!updateReq) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state     <= IDLE;
      updateAck <= 1'b0;
    end else begin
      state     <= stateNext;
      updateAck <= ackNext;
    end
  end

  // Free-running scan, independent of the handshake
  assign prescalerNext  = prescaler + SCAN_DIVIDER_BITS'(1);
  assign digitIndexNext = (&prescaler) ? digitIndex + DigitW'(1) : digitIndex;

  // Outputs are computed from post-edge state so drive and scan stay aligned
  always_comb begin
    nibbleSel = dispValueNext[3:0];
    leadZero  = 1'b0;
    case (digitIndexNext)
      2'd1: begin
        nibbleSel = dispValueNext[7:4];
        leadZero  = (dispValueNext[15:4] == '0);
      end
      2'd2: begin
        nibbleSel = dispValueNext[11:8];
        leadZero  = (dispValueNext[15:8] == '0);
      end
      2'd3: begin
        nibbleSel = dispValueNext[15:12];
        leadZero  = (dispValueNext[15:12] == '0);
      end
      default: begin
        nibbleSel = dispValueNext[3:0];
        leadZero  = 1'b0;
      end
    endcase
  end

  hex_to_segments uHexDecode (
    .nibble  (nibbleSel),
    .glyph_c (glyph)
  );

  always_comb begin
    anodesNext   = ANODES_OFF;
    segmentsNext = SEG_BLANK;
    dpNext       = 1'b1;
    if (prescalerNext >= SCAN_DIVIDER_BITS'(GUARD_CYCLES)) begin
      anodesNext   = ~(AnodeW'(1) << digitIndexNext);
      segmentsNext = (BLANK_LEADING_ZEROS && leadZero) ? SEG_BLANK : glyph;
      dpNext       = ~dispMaskNext[digitIndexNext];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      dispValue  <= '0;
      dispMask   <= '0;
      prescaler  <= '0;
      digitIndex <= '0;
      anodes     <= ANODES_OFF;
      segments   <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      dispValue  <= dispValueNext;
      dispMask   <= dispMaskNext;
      prescaler  <= prescalerNext;
      digitIndex <= digitIndexNext;
      anodes     <= anodesNext;
      segments   <= segmentsNext;
      dp         <= dpNext;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner: two instances (blanking on/off,
// different guard lengths) compared every cycle against a timeline model.
module tb_seven_segment_scanner;

  localparam int DivBits = 3;
  localparam int Dwell   = 1 << DivBits;
  localparam int GuardA  = 1;
  localparam int GuardB  = 2;

  logic        clock;
  logic        resetN;
  logic        updateReq;
  logic [15:0] value;
  logic [3:0]  dpMask;
  logic        updateAckA, updateAckB;
  logic [3:0]  anodesA, anodesB;
  logic [6:0]  segmentsA, segmentsB;
  logic        dpA, dpB;

  seven_segment_scanner #(
    .SCAN_DIVIDER_BITS(DivBits), .GUARD_CYCLES(GuardA), .BLANK_LEADING_ZEROS(1'b1)
  ) dutA (
    .clock(clock), .resetN(resetN), .updateReq(updateReq), .value(value),
    .dpMask(dpMask), .updateAck(updateAckA), .anodes(anodesA),
    .segments(segmentsA), .dp(dpA)
  );

  seven_segment_scanner #(
    .SCAN_DIVIDER_BITS(DivBits), .GUARD_CYCLES(GuardB), .BLANK_LEADING_ZEROS(1'b0)
  ) dutB (
    .clock(clock), .resetN(resetN), .updateReq(updateReq), .value(value),
    .dpMask(dpMask), .updateAck(updateAckB), .anodes(anodesB),
    .segments(segmentsB), .dp(dpB)
  );

  always #5 clock = ~clock;

  logic [6:0] glyphTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int nTests = 0;
  int nFail  = 0;

  // Model: cycles since reset, latched word, and when the last request was taken
  int          mCnt, mEdge, mLast;
  bit          mArmed, mAck;
  logic [15:0] mVal;
  logic [3:0]  mMask;
  logic [25:0] expVec, maskVec, obsVec;

  assign obsVec = {updateAckA, updateAckB, anodesA, segmentsA, dpA, anodesB, segmentsB, dpB};

  function automatic logic [11:0] dispExp(input int cnt, input int g, input bit blank,
                                          input logic [15:0] v, input logic [3:0] m);
    int presc, dig;
    logic [3:0]  sel;
    logic [15:0] upper;
    logic [6:0]  seg;
    presc = cnt % Dwell;
    dig   = (cnt / Dwell) % 4;
    if (presc < g) return {4'hF, 7'h7F, 1'b1};
    sel   = 4'b0001 << dig;
    upper = v >> (4 * dig);
    seg   = glyphTable[upper[3:0]];
    if (blank && dig > 0 && upper == 16'h0) seg = 7'h7F;
    return {~sel, seg, ~m[dig]};
  endfunction

  function automatic logic [11:0] dispMaskBits(input int cnt, input int g);
    return ((cnt % Dwell) < g) ? {4'hF, 7'h00, 1'b1} : 12'hFFF;
  endfunction

  task automatic tick(input logic rn, input logic req, input logic [15:0] v, input logic [3:0] m);
    resetN = rn; updateReq = req; value = v; dpMask = m;
    @(posedge clock);
    mEdge++;
    if (!rn) begin
      mCnt = 0; mVal = '0; mMask = '0; mArmed = 1'b1; mLast = -10; mAck = 1'b0;
    end else begin
      mCnt++;
      mAck = (mEdge == mLast + 1);
      if (mArmed && req) begin
        mVal = v; mMask = m; mLast = mEdge; mArmed = 1'b0;
      end else if (!mArmed && mEdge >= mLast + 2 && !req) begin
        mArmed = 1'b1;
      end
    end
    expVec  = {mAck, mAck, dispExp(mCnt, GuardA, 1'b1, mVal, mMask),
               dispExp(mCnt, GuardB, 1'b0, mVal, mMask)};
    maskVec = {2'b11, dispMaskBits(mCnt, GuardA), dispMaskBits(mCnt, GuardB)};
    @(negedge clock);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 16'hFFFF, 4'hF);
      nTests++;
      if ({updateAckA, anodesA, segmentsA, dpA, updateAckB, anodesB, segmentsB, dpB} !==
          {1'b0, 4'hF, 7'h7F, 1'b1, 1'b0, 4'hF, 7'h7F, 1'b1}) begin
        nFail++;
        $display("FAIL reset_state got=%h want=%h", obsVec, {2'b00, 12'hFFF, 12'hFFF});
      end
    end
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 4 * Dwell + 4; i++) begin
      tick(1'b1, 1'b0, 16'h0000, 4'h0);
      nTests++;
      if ((obsVec & maskVec) !== (expVec & maskVec)) begin
        nFail++;
        $display("FAIL idle_scan edge=%0d got=%h want=%h", mEdge, obsVec & maskVec, expVec & maskVec);
      end
    end
  endtask

  task automatic test_update();
    int acks = 0;
    for (int i = 0; i < 5 + 4 * Dwell; i++) begin
      tick(1'b1, (i < 5), 16'h12AF, 4'b0100);
      if (updateAckA) acks++;
      nTests++;
      if ((obsVec & maskVec) !== (expVec & maskVec)) begin
        nFail++;
        $display("FAIL update_12AF edge=%0d got=%h want=%h", mEdge, obsVec & maskVec, expVec & maskVec);
      end
    end
    nTests++;
    if (acks != 1) begin
      nFail++;
      $display("FAIL update_ack_count got=%0d want=1", acks);
    end
  endtask

  task automatic test_blanking();
    for (int i = 0; i < 3 + 4 * Dwell; i++) begin
      tick(1'b1, (i == 0), 16'h0050, 4'b0000);
      nTests++;
      if ((obsVec & maskVec) !== (expVec & maskVec)) begin
        nFail++;
        $display("FAIL blanking_0050 edge=%0d got=%h want=%h", mEdge, obsVec & maskVec, expVec & maskVec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    logic        reqPat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] valPat [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0002,
                                16'h0002, 16'h0002, 16'h0002, 16'h0002};
    for (int i = 0; i < 8 + 4 * Dwell; i++) begin
      tick(1'b1, (i < 8) ? reqPat[i] : 1'b0, (i < 8) ? valPat[i] : 16'h0002, 4'b0001);
      if (updateAckA) acks++;
      nTests++;
      if ((obsVec & maskVec) !== (expVec & maskVec)) begin
        nFail++;
        $display("FAIL back_to_back edge=%0d got=%h want=%h", mEdge, obsVec & maskVec, expVec & maskVec);
      end
    end
    nTests++;
    if (acks != 2) begin
      nFail++;
      $display("FAIL back_to_back_acks got=%0d want=2", acks);
    end
    acks = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 1'b1, 16'h0003 + 16'(i), 4'b0010);
      if (updateAckA) acks++;
      nTests++;
      if ((obsVec & maskVec) !== (expVec & maskVec)) begin
        nFail++;
        $display("FAIL held_req edge=%0d got=%h want=%h", mEdge, obsVec & maskVec, expVec & maskVec);
      end
    end
    nTests++;
    if (acks != 1) begin
      nFail++;
      $display("FAIL held_req_acks got=%0d want=1", acks);
    end
    tick(1'b1, 1'b0, 16'h0000, 4'h0);
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b1, 16'hBEEF, 4'h3);
    tick(1'b0, 1'b1, 16'hBEEF, 4'h3);
    nTests++;
    if ({updateAckA, anodesA, dpA} !== {1'b0, 4'hF, 1'b1}) begin
      nFail++;
      $display("FAIL reset_mid_ack got=%b/%h want=0/f", updateAckA, anodesA);
    end
    tick(1'b1, 1'b1, 16'hBEEF, 4'h3);
    tick(1'b1, 1'b1, 16'hBEEF, 4'h3);
    nTests++;
    if (updateAckA !== 1'b1) begin
      nFail++;
      $display("FAIL reset_mid_reaccept got=%b want=1", updateAckA);
    end
    for (int i = 0; i < 4 * Dwell; i++) begin
      tick(1'b1, 1'b0, 16'h0000, 4'h0);
      nTests++;
      if ((obsVec & maskVec) !== (expVec & maskVec)) begin
        nFail++;
        $display("FAIL reset_mid_scan edge=%0d got=%h want=%h", mEdge, obsVec & maskVec, expVec & maskVec);
      end
    end
  endtask

  task automatic test_guard();
    int runLen = 0;
    int runs   = 0;
    for (int i = 0; i < 8 * Dwell; i++) begin
      tick(1'b1, 1'b0, 16'h0000, 4'h0);
      nTests++;
      if ($countones(~anodesA) > 1 || $countones(~anodesB) > 1) begin
        nFail++;
        $display("FAIL guard_overlap edge=%0d got=%h/%h want=one-hot-low", mEdge, anodesA, anodesB);
      end
      if (anodesB == 4'hF) runLen++;
      else begin
        if (runLen != 0 && runs > 0) begin
          nTests++;
          if (runLen != GuardB) begin
            nFail++;
            $display("FAIL guard_len edge=%0d got=%0d want=%0d", mEdge, runLen, GuardB);
          end
        end
        if (runLen != 0) runs++;
        runLen = 0;
      end
    end
  endtask

  task automatic test_random();
    logic req = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3, 0) == 0) req = ~req;
      tick(($urandom_range(63, 0) != 0), req, 16'($urandom), 4'($urandom));
      nTests++;
      if ((obsVec & maskVec) !== (expVec & maskVec)) begin
        nFail++;
        $display("FAIL random edge=%0d got=%h want=%h", mEdge, obsVec & maskVec, expVec & maskVec);
      end
    end
  endtask

  initial begin
    clock = 1'b0; resetN = 1'b0; updateReq = 1'b0; value = '0; dpMask = '0;
    mCnt = 0; mEdge = 0; mLast = -10; mArmed = 1'b1; mAck = 1'b0; mVal = '0; mMask = '0;
    expVec = '0; maskVec = '0;
    @(negedge clock);
    test_reset();
    test_idle_scan();
    test_update();
    test_blanking();
    test_back_to_back();
    test_reset_mid();
    test_guard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Multiplexed driver for the board's four-digit, common-anode seven-segment display. It is the consumer end of the single-bit req/ack handshake that our button press detectors produce: the block accepts a 16-bit value plus decimal-point mask on a request, acknowledges it, and continuously scans the four digits. It sits beside the up/down counter and shows the counter value (or any 16-bit word) in hex.

## Interface
- SCAN_DIVIDER_BITS, 16: digit dwell is 2^SCAN_DIVIDER_BITS clocks.
- GUARD_CYCLES, 4: clocks of all-anodes-off at the start of each dwell (anti-ghosting); must be < 2^SCAN_DIVIDER_BITS.
- BLANK_LEADING_ZEROS, 1: 1 = blank leading zero digits; digit 0 is never blanked.
- clock  input  1  system clock; the single clock domain.
- resetN  input  1  synchronous, active-low reset.
- updateReq  input  1  level request; high while value/dpMask are valid.
- value  input  16  four hex nibbles; [3:0] = digit 0 (rightmost).
- dpMask  input  4  decimal point enables, bit i = digit i.
- updateAck  output  1  one-cycle acknowledge pulse, registered.
- anodes  output  4  active-low digit enables, bit i = digit i.
- segments  output  7  active-low, bit order {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.

## Operation
- Handshake FSM, states IDLE, ACK, WAIT_LOW.
  - IDLE: on a clock edge with updateReq=1, latch value/dpMask into the display registers and go to ACK.
  - ACK: updateAck=1 for exactly this cycle; go to WAIT_LOW unconditionally.
  - WAIT_LOW: stay until updateReq=0 is sampled, then go to IDLE. This rejects a request that is held high after the ack, so one request is never accepted twice.
- Scan: a SCAN_DIVIDER_BITS-wide prescaler counts every clock and wraps. On wrap, the 2-bit digit index increments, 3 wraps to 0.
- Drive:
  - While prescaler < GUARD_CYCLES: anodes=4'b1111 and dp=1.
  - Otherwise: anodes has only bit [digitIndex] low; segments come from the hex decode of the selected nibble; dp=~dpMask[digitIndex].
- Hex decode: the standard 0-F glyphs; b and d are lowercase.
- Blanking (BLANK_LEADING_ZEROS=1): digit i>0 is blanked (segments=7'h7F, anode still asserted) when it and every higher nibble are 0. A blanked digit still shows its dp if the mask bit is set.
- Outputs are registered: segments, anodes and dp change on the same edge.

## Timing
- Reset (resetN=0 at an edge): FSM=IDLE, updateAck=0, display registers=0, dpMask=0, prescaler=0, digitIndex=0, anodes=4'b1111, segments=7'h7F, dp=1.
- Acceptance: with updateReq high at edge N in IDLE, the display registers update at edge N and updateAck is high from edge N+1 to N+2. The new value appears on outputs at the first non-guard cycle after edge N.
- Minimum spacing between accepted updates is 3 cycles: ACK, WAIT_LOW seeing low, then IDLE sampling high.
- Reset mid-handshake forces IDLE with ack low. If updateReq is still high after reset releases, it is accepted again; this is intended.
- updateReq during reset is ignored; no latch, no ack.
- Prescaler and digit index run independently of the handshake; an update never restarts the scan.
- Refresh period = 4·2^SCAN_DIVIDER_BITS clocks.

## Structure
- Shared package display_pkg: segment glyph constants 0-F, the blank constant 7'h7F, the all-off anode constant 4'b1111, and the FSM state encodings.
- One sub-module hex_to_segments: a 4-bit to 7-bit combinational decoder, reused by future display blocks.
- Top-level RTL: the FSM, prescaler, digit counter, blanking logic and output registers.

## Test plan
- Reset, then SCAN_DIVIDER_BITS=3, GUARD_CYCLES=1, no request: after the guard, digit 0 shows 7'b1000000 ("0"); digits 1-3 are blanked; dp=1 throughout.
- Request value=16'h12AF, dpMask=4'b0100, held 5 cycles: exactly one updateAck pulse, one cycle after acceptance. The scan shows F, A, 2, 1 on anodes 1110, 1101, 1011, 0111, with dp=0 only on digit 2.
- value=16'h0050, BLANK_LEADING_ZEROS=1: digits 3 and 2 are blanked, digit 1 shows "5", digit 0 shows "0". With BLANK_LEADING_ZEROS=0, all four digits are shown.
- Two requests (16'h0001 then 16'h0002), each separated by a one-cycle low: two acks, and the final display is 0002. A request that never drops produces only one ack.
- Assert resetN=0 in the ACK cycle: ack drops on the next edge, the display reverts to 0, anodes=4'b1111. With req still high after release, a second ack follows.
- Guard check: at every digit boundary, anodes=4'b1111 for exactly GUARD_CYCLES clocks, and at no time are two anodes low together.
